// File: rtl/gpio_in_filter.sv
// gpio_in_filter: per-pin synchronizer, debounce, edge-event pending flags and level irq.
// Define GPIO_IN_DEBOUNCE_EN to build the debounce counters; otherwise stable follows s2 directly.
module gpio_in_filter #(
   parameter int N = 8,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [N-1:0] pins_i,
   input  logic [N-1:0] dir_i,
   input  logic [N-1:0] rise_en_i,
   input  logic [N-1:0] fall_en_i,
   input  logic [N-1:0] irq_en_i,
   input  logic [N-1:0] clr_i,
   output logic [N-1:0] val_o,
   output logic [N-1:0] pend_o,
   output logic         irq_o
);
   if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65536) begin : g_bad_cycles
      $error("DEBOUNCE_CYCLES out of range 2..65536");
   end
   logic [N-1:0] s1, s2, stable, prev, pend, rise, fall;
   always_ff @(posedge clk_i) begin
      s1 <= rst_i ? '0 : pins_i;
      s2 <= rst_i ? '0 : s1;
   end
`ifdef GPIO_IN_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   logic [CW-1:0] cnt [N];
   // any return of s2 to the accepted level throws the partial count away
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < N; i++) begin
         if (rst_i) begin
            cnt[i] <= '0;
            stable[i] <= 1'b0;
         end else if (s2[i] == stable[i]) begin
            cnt[i] <= '0;
         end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt[i] <= '0;
            stable[i] <= s2[i];
         end else begin
            cnt[i] <= cnt[i] + CW'(1);
         end
      end
   end
`else
   always_ff @(posedge clk_i) begin
      stable <= rst_i ? '0 : s2;
   end
`endif
   assign rise = stable & ~prev;
   assign fall = ~stable & prev;
   // a new event outranks a coincident clear
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prev <= '0;
         pend <= '0;
      end else begin
         prev <= stable;
         pend <= (pend & ~clr_i) | (dir_i & ((rise & rise_en_i) | (fall & fall_en_i)));
      end
   end
   assign val_o  = stable;
   assign pend_o = pend;
   assign irq_o  = |(pend & irq_en_i);
endmodule

// File: tb/tb_gpio_in_filter.sv
// tb_gpio_in_filter: directed checks of gpio_in_filter with N=8, DEBOUNCE_CYCLES=4.
module tb_gpio_in_filter;
`ifdef GPIO_IN_DEBOUNCE_EN
   localparam int LAT = 5;
`else
   localparam int LAT = 2;
`endif
   logic clk = 1'b0, rst;
   logic [7:0] pins, dir, rise_en, fall_en, irq_en, clr, val, pend;
   logic irq;
   int nvec = 0, nerr = 0;
   gpio_in_filter #(.N(8), .DEBOUNCE_CYCLES(4)) dut (
      .clk_i(clk), .rst_i(rst), .pins_i(pins), .dir_i(dir), .rise_en_i(rise_en),
      .fall_en_i(fall_en), .irq_en_i(irq_en), .clr_i(clr), .val_o(val), .pend_o(pend), .irq_o(irq)
   );
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   initial begin
      pins = '0; dir = 8'hFF; rise_en = '0; fall_en = '0; irq_en = '0; clr = '0; rst = 1'b1;
      repeat (3) tick();
      chk("rst_val", val, 8'h00);
      chk("rst_pend", pend, 8'h00);
      chk("rst_irq", {7'b0, irq}, 8'h00);
      rst = 1'b0;
      tick();
      // pin 0 rises; s1 samples it on the next edge
      pins[0] = 1'b1;
      tick();
      repeat (LAT - 1) tick();
      chk("t1_early", val, 8'h00);
      tick();
      chk("t1_accept", val, 8'h01);
      tick();
      chk("t1_no_enable", pend, 8'h00);
      // pin 1 high for 3 synchronized cycles
      rise_en = 8'h02;
      pins[1] = 1'b1;
      repeat (3) tick();
      pins[1] = 1'b0;
      repeat (8) tick();
      chk("t2_val", val, 8'h01);
`ifdef GPIO_IN_DEBOUNCE_EN
      chk("t2_pend", pend, 8'h00);
`else
      chk("t2_pend", pend, 8'h02);
`endif
      clr = 8'hFF;
      tick();
      clr = '0;
      chk("t2_clr", pend, 8'h00);
      // pin 2 rising event with irq
      rise_en = 8'h04;
      irq_en = 8'h04;
      pins[2] = 1'b1;
      tick();
      repeat (LAT) tick();
      chk("t3_val", val, 8'h05);
      chk("t3_pend_early", pend, 8'h00);
      chk("t3_irq_early", {7'b0, irq}, 8'h00);
      tick();
      chk("t3_pend", pend, 8'h04);
      chk("t3_irq", {7'b0, irq}, 8'h01);
      rise_en = '0;
      dir = '0;
      repeat (2) tick();
      chk("t3_sticky", pend, 8'h04);
      dir = 8'hFF;
      clr = 8'h04;
      tick();
      clr = '0;
      chk("t3_clr_pend", pend, 8'h00);
      chk("t3_clr_irq", {7'b0, irq}, 8'h00);
      // pin 3 configured as output still reads back
      dir = 8'hF7;
      rise_en = 8'h08;
      fall_en = 8'h08;
      pins[3] = 1'b1;
      repeat (LAT + 2) tick();
      chk("t4_val_hi", val, 8'h0D);
      chk("t4_pend_hi", pend, 8'h00);
      pins[3] = 1'b0;
      repeat (LAT + 2) tick();
      chk("t4_val_lo", val, 8'h05);
      chk("t4_pend_lo", pend, 8'h00);
      dir = 8'hFF;
      // pin 4: fall event coinciding with clear
      rise_en = 8'h10;
      fall_en = 8'h10;
      irq_en = 8'h14;
      pins[4] = 1'b1;
      tick();
      repeat (LAT) tick();
      tick();
      chk("t5_rise_pend", pend, 8'h10);
      chk("t5_rise_irq", {7'b0, irq}, 8'h01);
      pins[4] = 1'b0;
      tick();
      repeat (LAT - 1) tick();
      chk("t5_val_still_hi", val, 8'h15);
      tick();
      chk("t5_val_fell", val, 8'h05);
      clr = 8'h10;
      tick();
      clr = '0;
      chk("t5_set_wins", pend, 8'h10);
      // pin 5: reset in mid count
      rise_en = 8'h20;
      fall_en = '0;
      pins[5] = 1'b1;
      repeat (3) tick();
      chk("t6_pre_irq", {7'b0, irq}, 8'h01);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_rst_val", val, 8'h00);
      chk("t6_rst_pend", pend, 8'h00);
      chk("t6_rst_irq", {7'b0, irq}, 8'h00);
      tick();
      repeat (LAT - 1) tick();
      chk("t6_early", val, 8'h00);
      tick();
      chk("t6_accept", val, 8'h25);
      tick();
      chk("t6_pend", pend, 8'h20);
      chk("t6_irq", {7'b0, irq}, 8'h00);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/gpio_in_filter.md
GPIO_IN_FILTER -- requirements
Module: gpio_in_filter

Interface
REQ-001 Parameter N, default 8: number of GPIO pins handled.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16: consecutive synchronized cycles a new level must persist before acceptance; legal range 2..65536.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 pins_i  input  N  raw pin levels read back from the bidirectional pin buffers; asynchronous to clk_i.
REQ-006 dir_i  input  N  per-pin direction (INPUT=1; OUTPUT=0).
REQ-007 rise_en_i  input  N  per-pin rising-edge event enable.
REQ-008 fall_en_i  input  N  per-pin falling-edge event enable.
REQ-009 irq_en_i  input  N  per-pin interrupt mask (1 = pending bit may raise irq_o).
REQ-010 clr_i  input  N  per-pin write-one-to-clear pulse for pending bits.
REQ-011 val_o  output  N  synchronized, filtered pin level.
REQ-012 pend_o  output  N  per-pin sticky edge-event pending flags.
REQ-013 irq_o  output  1  level interrupt request.

Function
REQ-014 Each pin SHALL pass through a two-flop synchronizer (s1, s2) before any other logic.
REQ-015 Debounce: each pin SHALL keep a stable register and a counter of width clog2(DEBOUNCE_CYCLES).
REQ-016 When s2 equals stable, the counter SHALL clear to 0.
REQ-017 When s2 differs from stable and the counter is below DEBOUNCE_CYCLES-1, the counter SHALL increment.
REQ-018 When s2 differs from stable and the counter equals DEBOUNCE_CYCLES-1, stable SHALL load s2 and the counter SHALL clear.
REQ-019 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL not change val_o, because any return of s2 to stable clears the counter.
REQ-020 val_o SHALL equal stable, and SHALL be registered.
REQ-021 Latency: for a level held steady, val_o SHALL change DEBOUNCE_CYCLES+1 rising edges after the edge at which s1 first samples the new level.
REQ-022 val_o SHALL track the pin regardless of dir_i, so that output pins read back.
REQ-023 Edge detection: a prev register SHALL hold val_o delayed one cycle.
REQ-024 Rise = val_o & ~prev; fall = ~val_o & prev.
REQ-025 pend_o[i] SHALL set on the edge after val_o[i] changes, if dir_i[i]=1 and the matching enable is 1 in that detection cycle.
REQ-026 pend_o[i] SHALL remain set until clr_i[i]=1 clears it on the next edge.
REQ-027 If set and clear coincide on a pin, set SHALL win.
REQ-028 Pins with dir_i=0 SHALL never set pend_o.
REQ-029 Changing dir_i, rise_en_i or fall_en_i SHALL NOT clear existing pend_o bits.
REQ-030 irq_o SHALL equal the OR of (pend_o & irq_en_i), and SHALL be combinational from those registers.

Reset
REQ-031 While rst_i=1 at a clock edge, s1, s2, stable, prev, all counters and pend_o SHALL go to 0; val_o=0 and irq_o=0.
REQ-032 Reset asserted mid-debounce SHALL discard the partial count.
REQ-033 After reset, a pin held at 1 SHALL produce a normal rising event once accepted, per REQ-021.

Configuration
REQ-034 Macro GPIO_IN_DEBOUNCE_EN selects whether the debounce filter is built.
REQ-035 With GPIO_IN_DEBOUNCE_EN defined, the debounce filter of REQ-015..REQ-021 SHALL be built.
REQ-036 Without GPIO_IN_DEBOUNCE_EN, counters SHALL be omitted, DEBOUNCE_CYCLES SHALL be ignored, and stable SHALL load s2 every cycle.
REQ-037 Without GPIO_IN_DEBOUNCE_EN, val_o latency SHALL be 2 edges after s1 samples the new level.
REQ-038 All other behaviour SHALL be identical in both builds.

Verification (N=8, DEBOUNCE_CYCLES=4, debounce enabled unless stated)
REQ-039 The bench SHALL cover: pins_i[0] 0->1 sampled by s1 at edge 10 -> val_o[0]=1 after edge 15, not before.
REQ-040 The bench SHALL cover: pins_i[1] high for 3 synchronized cycles then low -> val_o[1] stays 0, pend_o[1] stays 0.
REQ-041 The bench SHALL cover: dir_i=8'hFF, rise_en_i[2]=1, irq_en_i[2]=1, pin 2 rises -> pend_o[2]=1 one edge after val_o[2] rises, irq_o=1; clr_i[2] pulse -> pend_o[2]=0, irq_o=0 next edge.
REQ-042 The bench SHALL cover: dir_i[3]=0, rise_en_i[3]=1, pin 3 toggles -> val_o[3] follows, pend_o[3] stays 0.
REQ-043 The bench SHALL cover: fall event on pin 4 in the same cycle as clr_i[4]=1 with pend_o[4] already set -> pend_o[4] remains 1.
REQ-044 The bench SHALL cover: rst_i pulsed with pin 5 high during counting -> all outputs 0; val_o[5]=1 DEBOUNCE_CYCLES+1 edges after the first post-reset edge at which s1 samples 1; rise event raised. Build without GPIO_IN_DEBOUNCE_EN -> same stimulus, latency 2 edges.
